// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_ctrl_pkg;

    localparam int          INSTR_W         = 32;
    localparam logic [31:0] DEFAULT_BOOT_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        RUN,
        ERR
    } state_e;

endpackage

// File: rtl/imem_wr_stage.sv
// Registered write port: one cycle between an accepted word and the memory write strobe.
module imem_wr_stage
    import imem_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [31:0]        wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    output logic               imem_we,
    output logic [31:0]        imem_waddr,
    output logic [INSTR_W-1:0] imem_wdata
);

    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [INSTR_W-1:0] data_q, data_d;

    always_comb begin
        we_d   = wr_en;
        addr_d = wr_en ? wr_addr : addr_q;
        data_d = wr_en ? wr_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_waddr = addr_q;
    assign imem_wdata = data_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot/reprogram loader: streams words into instruction memory, holds the core
// while loading, then forwards fetch addresses and flags read-data validity.
//
// state | meaning
// IDLE  | after reset, core held, waiting for load_start
// LOAD  | accepting stream words, one write per handshake
// DRAIN | final write lands, core still held
// RUN   | core executing, fetch addresses forwarded
// ERR   | stream overflowed memory, core held until load_start
module imem_load_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int          MEMORY_SIZE = 64,
    parameter logic [31:0] BOOT_PC     = DEFAULT_BOOT_PC,
    localparam int         CNT_W       = $clog2(MEMORY_SIZE) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic               fetch_req,
    input  logic [31:0]        fetch_addr,
    output logic               fetch_valid,
    output logic               fetch_misalign,
    output logic               core_run,
    output logic               imem_we,
    output logic [31:0]        imem_waddr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic [31:0]        imem_raddr,
    output logic [CNT_W-1:0]   load_count,
    output logic               load_error
);

    localparam logic [CNT_W-1:0] MEM_WORDS = CNT_W'(MEMORY_SIZE);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             error_q, error_d;
    logic             fvalid_q, fvalid_d;
    logic             misalign_q, misalign_d;
    logic             handshake;
    logic             grant;

    assign core_run = (state_q == RUN);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        error_d    = error_q;
        // load_start takes priority over a word offered in the same cycle
        load_ready = (state_q == LOAD) && (count_q < MEM_WORDS) && !load_start;
        handshake  = load_valid && load_ready;
        grant      = fetch_req && core_run;
        fvalid_d   = grant;
        misalign_d = grant ? (fetch_addr[1:0] != 2'b00) : misalign_q;

        if (load_start) begin
            state_d = LOAD;
            count_d = '0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (handshake) begin
                        count_d = count_q + CNT_W'(1);
                        if (load_last) state_d = DRAIN;
                    end else if (load_valid && (count_q == MEM_WORDS)) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
                DRAIN:   state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            error_q    <= 1'b0;
            fvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            error_q    <= error_d;
            fvalid_q   <= fvalid_d;
            misalign_q <= misalign_d;
        end
    end

    imem_wr_stage u_wr_stage (
        .clk        (clk),
        .rst_n      (reset),
        .wr_en      (handshake),
        .wr_addr    ({{(32-CNT_W){1'b0}}, count_q}),
        .wr_data    (load_data),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata)
    );

    assign imem_raddr     = core_run ? fetch_addr : BOOT_PC;
    assign fetch_valid    = fvalid_q;
    assign fetch_misalign = misalign_q;
    assign load_count     = count_q;
    assign load_error     = error_q;

endmodule
